// File: rtl/gpu_mem_comb_pkg.sv
// gpu_mem_comb_pkg: mode constants and lane-mapping helpers for the GPU memory combinator.
// Helpers work on a wide fixed vector so one set of functions serves any W/LANES
// combination up to MAX_BITS total bits; callers zero-extend in and truncate out.
package gpu_mem_comb_pkg;
    localparam logic MODE_PACK   = 1'b0;
    localparam logic MODE_UNPACK = 1'b1;
    localparam int   MAX_BITS    = 1024;

    typedef logic [MAX_BITS-1:0] vec_t;

    function automatic vec_t lo_mask(input int w);
        return (vec_t'(1) << (w / 2)) - vec_t'(1);
    endfunction

    function automatic vec_t hi_mask(input int w);
        return ((vec_t'(1) << w) - vec_t'(1)) ^ lo_mask(w);
    endfunction

    // Even output word keeps the weight's high half and takes the payload's
    // high half; odd output word takes the payload's low half.
    function automatic vec_t pack_lanes(input vec_t payload, input vec_t weights,
                                        input int w, input int lanes);
        vec_t res, p, lo, hi;
        res = '0;
        lo  = lo_mask(w);
        hi  = hi_mask(w);
        for (int i = 0; i < lanes; i++) begin
            p   = (payload >> (i * w)) & (lo | hi);
            res = res | ((((weights >> (2 * i * w)) & hi) | (p >> (w / 2))) << (2 * i * w));
            res = res | ((((weights >> ((2 * i + 1) * w)) & hi) | (p & lo)) << ((2 * i + 1) * w));
        end
        return res;
    endfunction

    // Rebuild payload word i from the low halves of combined words 2i and 2i+1.
    function automatic vec_t unpack_lanes(input vec_t weights, input int w, input int lanes);
        vec_t res;
        res = '0;
        for (int i = 0; i < lanes; i++)
            res = res | (((((weights >> (2 * i * w)) & lo_mask(w)) << (w / 2)) |
                          ((weights >> ((2 * i + 1) * w)) & lo_mask(w))) << (i * w));
        return res;
    endfunction
endpackage

// File: rtl/gpu_mem_combinator_pipe_if.sv
// gpu_mem_combinator_pipe_if: input/output handshake bundle of the combinator.
//   in_*  : beat from the weight fetch path (valid/ready, mode, payload, weights)
//   out_* : buffered result toward the memory write port (valid/ready, data, mode)
// slave = the combinator, master = the surrounding producer/consumer.
interface gpu_mem_combinator_pipe_if #(
    parameter int W     = 16,
    parameter int LANES = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic [LANES*W-1:0]       in_payload;
    logic [2*LANES*W-1:0]     in_weights;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_mode;
    logic [2*LANES*W-1:0]     out_data;

    modport master (
        output in_valid, in_mode, in_payload, in_weights, out_ready,
        input  in_ready, out_valid, out_data, out_mode
    );

    modport slave (
        input  in_valid, in_mode, in_payload, in_weights, out_ready,
        output in_ready, out_valid, out_data, out_mode
    );
endinterface

// File: rtl/gpu_mem_comb_fifo.sv
// gpu_mem_comb_fifo: DEPTH x DW synchronous FIFO with asynchronous active-low reset.
//   clock, reset     : rising-edge clock, async active-low reset
//   push, din        : write request (ignored when full)
//   pop              : read request (ignored when empty)
//   dout             : head entry (zero after reset)
//   full, empty, occupancy : registered fill state
module gpu_mem_comb_fifo #(
    parameter int DEPTH = 2,
    parameter int DW    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                din,
    output logic [DW-1:0]                dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push)
            mem_d[wr_ptr_q] = din;
        wr_ptr_d = !do_push ? wr_ptr_q : (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = !do_pop ? rd_ptr_q : (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout      = mem_q[rd_ptr_q];
    assign full      = count_q == CW'(DEPTH);
    assign empty     = count_q == '0;
    assign occupancy = count_q;
endmodule

// File: rtl/gpu_mem_combinator_pipe.sv
// gpu_mem_combinator_pipe: pipelined PACK/UNPACK combinator with output buffer and txn counter.
//   clock, reset : rising-edge clock, async active-low reset
//   bus          : slave side of the in/out valid-ready bundle
//   txn_count    : number of output handshakes, wrapping at 2^CNT_W
module gpu_mem_combinator_pipe
    import gpu_mem_comb_pkg::*;
#(
    parameter int W     = 16,
    parameter int LANES = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    gpu_mem_combinator_pipe_if.slave bus,
    output logic [CNT_W-1:0]     txn_count
);
    localparam int OW = 2 * LANES * W;
    localparam int CW = $clog2(DEPTH + 1);

    logic [OW-1:0]    result;
    logic [OW:0]      head;
    logic             full, empty, push, pop;
    logic [CW-1:0]    occupancy;
    logic [CNT_W-1:0] txn_count_q, txn_count_d;

    always_comb begin
        result = (bus.in_mode == MODE_UNPACK)
               ? OW'(unpack_lanes(vec_t'(bus.in_weights), W, LANES))
               : OW'(pack_lanes(vec_t'(bus.in_payload), vec_t'(bus.in_weights), W, LANES));
        push        = bus.in_valid & ~full;
        pop         = ~empty & bus.out_ready;
        txn_count_d = txn_count_q + CNT_W'(pop);
    end

    gpu_mem_comb_fifo #(
        .DEPTH (DEPTH),
        .DW    (OW + 1)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .din       ({bus.in_mode, result}),
        .dout      (head),
        .full      (full),
        .empty     (empty),
        .occupancy (occupancy)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            txn_count_q <= '0;
        else
            txn_count_q <= txn_count_d;
    end

    // Ready depends only on registered occupancy, so a full buffer refuses
    // a beat even while the head is being popped.
    assign bus.in_ready                = occupancy < CW'(DEPTH);
    assign bus.out_valid               = ~empty;
    assign {bus.out_mode, bus.out_data} = head;
    assign txn_count                   = txn_count_q;
endmodule

// File: tb/tb_gpu_mem_combinator_pipe.sv
// tb_gpu_mem_combinator_pipe: scoreboard bench for the GPU memory combinator.
module tb_gpu_mem_combinator_pipe;
    import gpu_mem_comb_pkg::*;

    localparam int W     = 16;
    localparam int LANES = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int OW    = 2 * LANES * W;
    localparam int PWID  = LANES * W;

    typedef struct packed {
        logic          mode;
        logic [OW-1:0] data;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] exp_txn = '0;
    exp_t             sb[$];
    exp_t             e;
    int               checks = 0;
    int               fails  = 0;
    logic             rnd_on;

    always #5 clock = ~clock;

    gpu_mem_combinator_pipe_if #(.W(W), .LANES(LANES)) bus ();

    gpu_mem_combinator_pipe #(
        .W(W), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .txn_count (txn_count)
    );

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic m, input logic [PWID-1:0] p, input logic [OW-1:0] w);
        exp_t r;
        logic [W-1:0] pw;
        r.mode = m;
        r.data = '0;
        for (int i = 0; i < LANES; i++) begin
            pw = p[i*W +: W];
            if (!m) begin
                r.data[2*i*W +: W]     = {w[2*i*W + W/2 +: W/2], pw[W-1:W/2]};
                r.data[(2*i+1)*W +: W] = {w[(2*i+1)*W + W/2 +: W/2], pw[W/2-1:0]};
            end else begin
                r.data[i*W +: W] = {w[2*i*W +: W/2], w[(2*i+1)*W +: W/2]};
            end
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] rnd_w();
        logic [OW-1:0] r;
        for (int i = 0; i < OW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [PWID-1:0] rnd_p();
        logic [PWID-1:0] r;
        for (int i = 0; i < PWID / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // Handshakes are sampled at the falling edge; inputs only change 1 time unit
    // after a rising edge, so what is seen here is what the next rising edge sees.
    always @(negedge clock) begin
        if (reset) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0)
                    chk("sb_nonempty", OW'(sb.size()), OW'(1));
                else begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_mode", OW'(bus.out_mode), OW'(e.mode));
                end
                exp_txn++;
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.in_mode, bus.in_payload, bus.in_weights));
        end
    end

    task automatic send(input logic m, input logic [PWID-1:0] p, input logic [OW-1:0] w);
        bus.in_valid   = 1'b1;
        bus.in_mode    = m;
        bus.in_payload = p;
        bus.in_weights = w;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (bus.in_ready) break;
        end
        if (!bus.in_ready) chk("send_timeout", OW'(bus.in_ready), OW'(1));
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (!bus.out_valid) break;
        end
        chk({tag, "_drained"}, OW'(bus.out_valid), OW'(0));
        chk({tag, "_txn"}, OW'(txn_count), OW'(exp_txn));
    endtask

    initial begin
        logic [PWID-1:0] p;
        logic [OW-1:0]   w;
        bus.in_valid   = 1'b0;
        bus.in_mode    = 1'b0;
        bus.in_payload = '0;
        bus.in_weights = '0;
        bus.out_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", OW'(bus.out_valid), OW'(0));
        chk("rst_txn", OW'(txn_count), OW'(0));
        chk("rst_out_data", bus.out_data, OW'(0));
        chk("rst_out_mode", OW'(bus.out_mode), OW'(0));
        #11 reset = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", OW'(bus.in_ready), OW'(1));
        @(posedge clock);
        #1;

        // Test 1: PACK, one-cycle latency, then pop
        bus.out_ready = 1'b1;
        p = '0; p[15:0] = 16'hABCD;
        w = '0; w[15:0] = 16'h1234; w[31:16] = 16'h5678;
        send(MODE_PACK, p, w);
        chk("t1_valid", OW'(bus.out_valid), OW'(1));
        chk("t1_out0", OW'(bus.out_data[15:0]), OW'(16'h12AB));
        chk("t1_out1", OW'(bus.out_data[31:16]), OW'(16'h56CD));
        chk("t1_mode", OW'(bus.out_mode), OW'(0));
        @(posedge clock);
        #1;
        chk("t1_txn", OW'(txn_count), OW'(1));
        chk("t1_empty", OW'(bus.out_valid), OW'(0));

        // Test 2: UNPACK, payload ignored
        w = '0; w[15:0] = 16'h12AB; w[31:16] = 16'h56CD;
        send(MODE_UNPACK, rnd_p(), w);
        chk("t2_data", bus.out_data, OW'(16'hABCD));
        chk("t2_mode", OW'(bus.out_mode), OW'(1));
        drain("t2");

        // Test 3: backpressure with a full buffer
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        send(MODE_PACK, rnd_p(), rnd_w());
        send(MODE_UNPACK, rnd_p(), rnd_w());
        fork
            send(MODE_PACK, rnd_p(), rnd_w());
        join_none
        @(negedge clock);
        chk("t3_full_ready", OW'(bus.in_ready), OW'(0));
        @(negedge clock);
        chk("t3_full_ready2", OW'(bus.in_ready), OW'(0));
        chk("t3_full_valid", OW'(bus.out_valid), OW'(1));
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("t3_no_writethrough", OW'(bus.in_ready), OW'(0));
        @(negedge clock);
        chk("t3_c_next_cycle", OW'(bus.in_ready), OW'(1));
        wait fork;
        drain("t3");

        // Test 4: push and pop together at occupancy 1
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        send(MODE_PACK, rnd_p(), rnd_w());
        bus.out_ready = 1'b1;
        send(MODE_UNPACK, rnd_p(), rnd_w());
        chk("t4_valid", OW'(bus.out_valid), OW'(1));
        chk("t4_occ1_ready", OW'(bus.in_ready), OW'(1));
        chk("t4_txn", OW'(txn_count), OW'(exp_txn));
        drain("t4");

        // Random traffic with random consumer stalls
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clock);
                #1;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int n = 0; n < 40; n++)
            send(1'($urandom_range(0, 1)), rnd_p(), rnd_w());
        rnd_on = 1'b0;
        wait fork;
        drain("rnd");

        // Test 5: asynchronous reset mid-cycle with two entries buffered
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        send(MODE_PACK, rnd_p(), rnd_w());
        send(MODE_UNPACK, rnd_p(), rnd_w());
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_valid", OW'(bus.out_valid), OW'(0));
        chk("t5_async_txn", OW'(txn_count), OW'(0));
        sb.delete();
        exp_txn = '0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(negedge clock);
        chk("t5_ready", OW'(bus.in_ready), OW'(1));
        chk("t5_no_stale", OW'(bus.out_valid), OW'(0));
        chk("t5_data_zero", bus.out_data, OW'(0));
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("t5_still_empty", OW'(bus.out_valid), OW'(0));

        // Test 6: counter wrap after 65536 pops
        @(posedge clock);
        #1;
        for (int n = 0; n < 65535; n++)
            send(MODE_PACK, rnd_p(), rnd_w());
        drain("t6a");
        chk("t6_ffff", OW'(txn_count), OW'(16'hFFFF));
        @(posedge clock);
        #1;
        send(MODE_UNPACK, rnd_p(), rnd_w());
        drain("t6b");
        chk("t6_wrap", OW'(txn_count), OW'(0));
        chk("sb_leftover", OW'(sb.size()), OW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
